// File: rtl/spi_temp_reader.sv
// spi_temp_reader
// SPI mode-0 read-only master. A rising edge on trig_in runs one transaction:
// CS low, frame_bits bits clocked in MSB-first on SCLK rising edges, CS high.
// The received word is published on data_out with a one-cycle valid_out strobe.
//
// Ports:
//   clk_in      system clock, rising edge
//   rst_in      asynchronous active-high reset
//   trig_in     start request; only a rising edge starts a frame
//   miso_in     serial data from the sensor
//   sclk_out    SPI clock, idles low
//   cs_n_out    chip select, active low
//   data_out    last completed frame, held between frames
//   valid_out   one-cycle strobe when data_out updates
//   busy_out    high from CS assertion through the valid_out cycle
//   overrun_out one-cycle pulse when a trigger arrives while a frame is active
module spi_temp_reader #(
  parameter int clk_div    = 25,
  parameter int frame_bits = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  trig_in,
  input  logic                  miso_in,
  output logic                  sclk_out,
  output logic                  cs_n_out,
  output logic [frame_bits-1:0] data_out,
  output logic                  valid_out,
  output logic                  busy_out,
  output logic                  overrun_out
);

  localparam int cnt_w = (clk_div > 1) ? $clog2(clk_div) : 1;
  localparam int bit_w = $clog2(2 * frame_bits + 1);
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(clk_div - 1);
  localparam logic [bit_w-1:0] bit_last = bit_w'(2 * frame_bits - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t                state;
  logic                  trig_q;
  logic [cnt_w-1:0]      cnt;
  logic [bit_w-1:0]      bit_cnt;
  logic [frame_bits-1:0] shift_reg;
  logic                  rise;
  logic                  cnt_wrap;

  assign rise     = trig_in & ~trig_q;
  assign cnt_wrap = (cnt == cnt_last);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state       <= IDLE;
      // Starts at 1 so a trigger held high through reset is not seen as an edge.
      trig_q      <= 1'b1;
      cnt         <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      sclk_out    <= 1'b0;
      cs_n_out    <= 1'b1;
      data_out    <= '0;
      valid_out   <= 1'b0;
      busy_out    <= 1'b0;
      overrun_out <= 1'b0;
    end else begin
      trig_q      <= trig_in;
      overrun_out <= rise && (state != IDLE);

      case (state)
        IDLE: begin
          valid_out <= 1'b0;
          busy_out  <= 1'b0;
          sclk_out  <= 1'b0;
          cnt       <= '0;
          bit_cnt   <= '0;
          if (rise) begin
            state    <= SETUP;
            cs_n_out <= 1'b0;
            busy_out <= 1'b1;
          end
        end

        // CS-to-first-SCLK setup time of one half-period.
        SETUP: begin
          if (cnt_wrap) begin
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        SHIFT: begin
          if (cnt_wrap) begin
            cnt      <= '0;
            sclk_out <= ~sclk_out;
            bit_cnt  <= bit_cnt + 1'b1;
            // Sample on the edge that drives SCLK high (mode 0).
            if (!sclk_out) begin
              shift_reg <= {shift_reg[frame_bits-2:0], miso_in};
            end
            // The final toggle returns SCLK low.
            if (bit_cnt == bit_last) begin
              state <= HOLD;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Last-SCLK-to-CS-release hold time of one half-period.
        HOLD: begin
          if (cnt_wrap) begin
            cnt       <= '0;
            state     <= DONE;
            cs_n_out  <= 1'b1;
            data_out  <= shift_reg;
            valid_out <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          state     <= IDLE;
          valid_out <= 1'b0;
          busy_out  <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          cs_n_out <= 1'b1;
          sclk_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_temp_reader.sv
module tb_spi_temp_reader;

  logic clk = 1'b0;
  logic rst;
  logic trig_a, trig_d;
  logic miso_a, miso_d;
  logic sclk_a, sclk_d, cs_a, cs_d;
  logic [15:0] data_a, data_d;
  logic valid_a, valid_d, busy_a, busy_d, ovr_a, ovr_d;

  always #5 clk = ~clk;

  spi_temp_reader #(.clk_div(2), .frame_bits(16)) dut (
    .clk_in(clk), .rst_in(rst), .trig_in(trig_a), .miso_in(miso_a),
    .sclk_out(sclk_a), .cs_n_out(cs_a), .data_out(data_a),
    .valid_out(valid_a), .busy_out(busy_a), .overrun_out(ovr_a)
  );

  spi_temp_reader dut_d (
    .clk_in(clk), .rst_in(rst), .trig_in(trig_d), .miso_in(miso_d),
    .sclk_out(sclk_d), .cs_n_out(cs_d), .data_out(data_d),
    .valid_out(valid_d), .busy_out(busy_d), .overrun_out(ovr_d)
  );

  // Monitor selects which instance the observer watches/drives.
  logic sel = 1'b0;
  logic m_cs, m_sclk, m_valid, m_busy, m_ovr;
  logic [15:0] m_data;
  assign m_cs    = sel ? cs_d    : cs_a;
  assign m_sclk  = sel ? sclk_d  : sclk_a;
  assign m_valid = sel ? valid_d : valid_a;
  assign m_busy  = sel ? busy_d  : busy_a;
  assign m_ovr   = sel ? ovr_d   : ovr_a;
  assign m_data  = sel ? data_d  : data_a;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [15:0] sens_a[$];
  logic [15:0] sens_d[$];
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];

  // Sensor models: present MSB at CS fall, advance on each SCLK falling edge.
  logic [15:0] word_a, word_d;
  int idx_a, idx_d;
  always @(negedge cs_a) begin
    word_a = (sens_a.size() > 0) ? sens_a.pop_front() : 16'h0000;
    idx_a  = 15;
    miso_a = word_a[15];
  end
  always @(negedge sclk_a) begin
    if (cs_a === 1'b0) begin
      idx_a = idx_a - 1;
      if (idx_a >= 0) miso_a = word_a[idx_a];
    end
  end
  always @(negedge cs_d) begin
    word_d = (sens_d.size() > 0) ? sens_d.pop_front() : 16'h0000;
    idx_d  = 15;
    miso_d = word_d[15];
  end
  always @(negedge sclk_d) begin
    if (cs_d === 1'b0) begin
      idx_d = idx_d - 1;
      if (idx_d >= 0) miso_d = word_d[idx_d];
    end
  end

  // Runs a window of cycles, driving the selected trigger from a schedule and
  // recording what the DUT did. Received words go to got_q.
  task automatic observe(input int cycles, input int start, input int period,
                         input int width, input int n,
                         output int frames, output int valids, output int ovrs,
                         output int low_len, output int edges, output int rises,
                         output int bad, output int per);
    logic prev_cs, prev_sclk, t;
    int cur_low, r1, r2;
    frames = 0; valids = 0; ovrs = 0; low_len = 0; edges = 0; rises = 0;
    bad = 0; per = 0; cur_low = 0; r1 = -1; r2 = -1;
    prev_cs = m_cs; prev_sclk = m_sclk;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (!m_cs) begin
        if (prev_cs) begin frames++; cur_low = 0; end
        cur_low++;
        if (m_valid) bad++;
      end else if (!prev_cs) begin
        low_len = cur_low;
        if (!m_valid) bad++;
      end
      if (m_busy !== (!m_cs || m_valid)) bad++;
      if (m_sclk !== prev_sclk) edges++;
      if (m_sclk && !prev_sclk) begin
        rises++;
        if (r1 < 0) r1 = i; else if (r2 < 0) r2 = i;
      end
      if (m_valid) begin valids++; got_q.push_back(m_data); end
      if (m_ovr) ovrs++;
      prev_cs = m_cs; prev_sclk = m_sclk;
      t = (i >= start) && (((i - start) % period) < width) && ((i - start) < n * period);
      if (sel) trig_d = t; else trig_a = t;
    end
    if (r2 >= 0) per = r2 - r1;
  endtask

  task automatic test_reset;
    rst = 1'b1; trig_a = 1'b0; trig_d = 1'b0; miso_a = 1'b0; miso_d = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total_cnt++; if (cs_a !== 1'b1) $display("FAIL reset_cs got %b want 1", cs_a); else pass_cnt++;
    total_cnt++; if (sclk_a !== 1'b0) $display("FAIL reset_sclk got %b want 0", sclk_a); else pass_cnt++;
    total_cnt++; if (data_a !== 16'h0) $display("FAIL reset_data got %h want 0000", data_a); else pass_cnt++;
    total_cnt++; if (valid_a !== 1'b0) $display("FAIL reset_valid got %b want 0", valid_a); else pass_cnt++;
    total_cnt++; if (busy_a !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_a); else pass_cnt++;
    total_cnt++; if (ovr_a !== 1'b0) $display("FAIL reset_overrun got %b want 0", ovr_a); else pass_cnt++;
    total_cnt++; if (cs_d !== 1'b1) $display("FAIL reset_cs_dflt got %b want 1", cs_d); else pass_cnt++;
    $display("reset: cs=%b sclk=%b data=%h valid=%b busy=%b ovr=%b", cs_a, sclk_a, data_a, valid_a, busy_a, ovr_a);
  endtask

  task automatic test_single;
    int fr, va, ov, ll, ed, ri, bd, pe;
    logic [15:0] g, e;
    sel = 1'b0;
    sens_a.push_back(16'hA5C3); exp_q.push_back(16'hA5C3);
    observe(100, 0, 1000, 1, 1, fr, va, ov, ll, ed, ri, bd, pe);
    total_cnt++; if (fr !== 1) $display("FAIL single_frames got %0d want 1", fr); else pass_cnt++;
    total_cnt++; if (ll !== 68) $display("FAIL single_cs_low got %0d want 68", ll); else pass_cnt++;
    total_cnt++; if (ed !== 32) $display("FAIL single_sclk_edges got %0d want 32", ed); else pass_cnt++;
    total_cnt++; if (ri !== 16) $display("FAIL single_sclk_rises got %0d want 16", ri); else pass_cnt++;
    total_cnt++; if (pe !== 4) $display("FAIL single_sclk_period got %0d want 4", pe); else pass_cnt++;
    total_cnt++; if (va !== 1) $display("FAIL single_valid_cycles got %0d want 1", va); else pass_cnt++;
    total_cnt++; if (bd !== 0) $display("FAIL single_valid_busy_timing got %0d errors want 0", bd); else pass_cnt++;
    total_cnt++; if (ov !== 0) $display("FAIL single_overrun got %0d want 0", ov); else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (got_q.size() == 0) $display("FAIL single_data got none want %h", e);
      else begin
        g = got_q.pop_front();
        if (g !== e) $display("FAIL single_data got %h want %h", g, e); else pass_cnt++;
        $display("single: data=%h expected=%h cs_low=%0d", g, e, ll);
      end
    end
  endtask

  task automatic test_level;
    int fr, va, ov, ll, ed, ri, bd, pe;
    logic [15:0] g, e;
    sel = 1'b0;
    sens_a.push_back(16'h1234); exp_q.push_back(16'h1234);
    observe(260, 0, 1000, 200, 1, fr, va, ov, ll, ed, ri, bd, pe);
    total_cnt++; if (fr !== 1) $display("FAIL level_frames got %0d want 1", fr); else pass_cnt++;
    total_cnt++; if (ov !== 0) $display("FAIL level_overrun got %0d want 0", ov); else pass_cnt++;
    sens_a.push_back(16'h8001); exp_q.push_back(16'h8001);
    observe(100, 5, 1000, 1, 1, fr, va, ov, ll, ed, ri, bd, pe);
    total_cnt++; if (fr !== 1) $display("FAIL level_retrigger_frames got %0d want 1", fr); else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (got_q.size() == 0) $display("FAIL level_data got none want %h", e);
      else begin
        g = got_q.pop_front();
        if (g !== e) $display("FAIL level_data got %h want %h", g, e); else pass_cnt++;
        $display("level: data=%h expected=%h", g, e);
      end
    end
  endtask

  task automatic test_overrun;
    int fr, va, ov, ll, ed, ri, bd, pe;
    logic [15:0] g, e;
    sel = 1'b0;
    sens_a.push_back(16'h3C5A); exp_q.push_back(16'h3C5A);
    observe(300, 0, 20, 1, 2, fr, va, ov, ll, ed, ri, bd, pe);
    total_cnt++; if (ov !== 1) $display("FAIL overrun_pulses got %0d want 1", ov); else pass_cnt++;
    total_cnt++; if (fr !== 1) $display("FAIL overrun_frames got %0d want 1", fr); else pass_cnt++;
    total_cnt++; if (ll !== 68) $display("FAIL overrun_cs_low got %0d want 68", ll); else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (got_q.size() == 0) $display("FAIL overrun_data got none want %h", e);
      else begin
        g = got_q.pop_front();
        if (g !== e) $display("FAIL overrun_data got %h want %h", g, e); else pass_cnt++;
        $display("overrun: data=%h expected=%h pulses=%0d", g, e, ov);
      end
    end
  endtask

  task automatic test_back_to_back;
    int fr, va, ov, ll, ed, ri, bd, pe;
    logic [15:0] g, e;
    sel = 1'b0;
    sens_a.push_back(16'hFFFF); exp_q.push_back(16'hFFFF);
    sens_a.push_back(16'h0001); exp_q.push_back(16'h0001);
    // Second trigger lands in the first IDLE cycle after the valid strobe.
    observe(220, 0, 70, 1, 2, fr, va, ov, ll, ed, ri, bd, pe);
    total_cnt++; if (fr !== 2) $display("FAIL b2b_frames got %0d want 2", fr); else pass_cnt++;
    total_cnt++; if (ov !== 0) $display("FAIL b2b_overrun got %0d want 0", ov); else pass_cnt++;
    total_cnt++; if (bd !== 0) $display("FAIL b2b_valid_busy_timing got %0d errors want 0", bd); else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (got_q.size() == 0) $display("FAIL b2b_data got none want %h", e);
      else begin
        g = got_q.pop_front();
        if (g !== e) $display("FAIL b2b_data got %h want %h", g, e); else pass_cnt++;
        $display("b2b: data=%h expected=%h", g, e);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    int fr, va, ov, ll, ed, ri, bd, pe, k;
    sel = 1'b0;
    sens_a.push_back(16'h7E7E);
    @(negedge clk); trig_a = 1'b1;
    @(negedge clk); trig_a = 1'b0;
    repeat (28) @(negedge clk);
    k = 0;
    while (sclk_a !== 1'b1 && k < 8) begin @(negedge clk); k++; end
    total_cnt++; if (cs_a !== 1'b0 || sclk_a !== 1'b1) $display("FAIL midrst_in_shift got cs=%b sclk=%b want cs=0 sclk=1", cs_a, sclk_a); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++; if (cs_a !== 1'b1) $display("FAIL midrst_cs got %b want 1", cs_a); else pass_cnt++;
    total_cnt++; if (sclk_a !== 1'b0) $display("FAIL midrst_sclk got %b want 0", sclk_a); else pass_cnt++;
    total_cnt++; if (data_a !== 16'h0) $display("FAIL midrst_data got %h want 0000", data_a); else pass_cnt++;
    total_cnt++; if (valid_a !== 1'b0) $display("FAIL midrst_valid got %b want 0", valid_a); else pass_cnt++;
    trig_a = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    observe(150, 0, 1000, 150, 1, fr, va, ov, ll, ed, ri, bd, pe);
    trig_a = 1'b0;
    total_cnt++; if (fr !== 0) $display("FAIL midrst_held_trig_frames got %0d want 0", fr); else pass_cnt++;
    total_cnt++; if (va !== 0) $display("FAIL midrst_valids got %0d want 0", va); else pass_cnt++;
    $display("midrst: cs=%b sclk=%b data=%h frames_after=%0d", cs_a, sclk_a, data_a, fr);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_default_params;
    int fr, va, ov, ll, ed, ri, bd, pe;
    logic [15:0] g, e;
    sel = 1'b1;
    sens_d.push_back(16'h0190); exp_q.push_back(16'h0190);
    sens_d.push_back(16'h0191); exp_q.push_back(16'h0191);
    sens_d.push_back(16'hFE70); exp_q.push_back(16'hFE70);
    observe(3000, 0, 1000, 1, 3, fr, va, ov, ll, ed, ri, bd, pe);
    total_cnt++; if (fr !== 3) $display("FAIL dflt_frames got %0d want 3", fr); else pass_cnt++;
    total_cnt++; if (ll !== 850) $display("FAIL dflt_cs_low got %0d want 850", ll); else pass_cnt++;
    total_cnt++; if (pe !== 50) $display("FAIL dflt_sclk_period got %0d want 50", pe); else pass_cnt++;
    total_cnt++; if (ed !== 96) $display("FAIL dflt_sclk_edges got %0d want 96", ed); else pass_cnt++;
    total_cnt++; if (bd !== 0) $display("FAIL dflt_valid_busy_timing got %0d errors want 0", bd); else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (got_q.size() == 0) $display("FAIL dflt_data got none want %h", e);
      else begin
        g = got_q.pop_front();
        if (g !== e) $display("FAIL dflt_data got %h want %h", g, e); else pass_cnt++;
        $display("dflt: data=%h expected=%h cs_low=%0d", g, e, ll);
      end
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_level();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    test_default_params();
    total_cnt++;
    if (got_q.size() !== 0) $display("FAIL leftover_frames got %0d want 0", got_q.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/spi_temp_reader.md
Name: spi_temp_reader

Overview:
SPI mode-0 master that reads one temperature frame from the sensor each time the periodic timer fires. trig_in is driven by the timer's sig_out. A rising edge on trig_in starts one read-only transaction: assert CS, clock in frame_bits bits MSB-first, deassert CS. The received word is presented on data_out with a one-cycle valid_out strobe. This block is the consumer end of the timer's tick interface and the initiator end of the sensor's SPI link.

Parameters:
clk_div, 25, SCLK half-period in clk_in cycles (50 MHz / 50 = 1 MHz SCLK); legal range >= 1
frame_bits, 16, bits per SPI frame; also the width of data_out; legal range >= 2

Ports:
clk_in  input  1  system clock; all logic on rising edge
rst_in  input  1  asynchronous, active-high reset
trig_in  input  1  start request; only a rising edge is acted on (level or pulse accepted)
miso_in  input  1  serial data from sensor
sclk_out  output  1  SPI clock; idles low
cs_n_out  output  1  chip select, active low
data_out  output  frame_bits  last completed frame; held between frames
valid_out  output  1  one-cycle strobe when data_out updates
busy_out  output  1  high from CS assertion until the valid_out cycle inclusive
overrun_out  output  1  one-cycle pulse when a trig_in rising edge arrives while busy

Behaviour:
- Reset (async assert, sync release): sclk_out=0, cs_n_out=1, data_out=0, valid_out=0, busy_out=0, overrun_out=0, state=IDLE.
- Reset also sets the trig edge-detect register to 1, so a trig_in held high through reset does not start a frame.
- Edge detect: rise = trig_in & ~trig_q; trig_q <= trig_in every cycle.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> DONE -> IDLE.
- IDLE:
  - On a clock edge where rise=1: go to SETUP, cs_n_out=0, busy_out=1, half-period counter=0.
  - So cs_n_out falls on the first clk_in edge that samples trig_in high after it was low.
- SETUP: hold sclk_out=0 for clk_div cycles, then go to SHIFT.
- SHIFT:
  - Each time the counter reaches clk_div-1: counter resets and sclk_out toggles.
  - On a 0->1 toggle: shift_reg <= {shift_reg[frame_bits-2:0], miso_in}.
  - miso_in is sampled at the clk_in edge that drives sclk_out high.
  - After 2*frame_bits toggles (sclk_out back low): go to HOLD.
- HOLD: sclk_out=0, cs_n_out=0 for clk_div cycles, then go to DONE.
- DONE (one cycle):
  - cs_n_out=1, data_out<=shift_reg, valid_out=1, busy_out=1.
  - Next cycle: IDLE, valid_out=0, busy_out=0.
- Timing per frame:
  - cs_n_out is low for exactly (2*frame_bits+2)*clk_div cycles.
  - valid_out asserts on the cycle cs_n_out returns high.
- Triggers while not IDLE (SETUP through DONE):
  - The request is ignored and overrun_out pulses for one cycle.
  - The frame in progress is unaffected, and no request is queued.
- A rise in the same cycle the FSM is in IDLE after DONE starts a new frame normally.
- Bit counter width is $clog2(2*frame_bits+1); half-period counter width is max(1,$clog2(clk_div)).
- The counter wraps only at clk_div-1, never past it.
- Reset mid-frame: cs_n_out goes high and sclk_out goes low immediately (asynchronous). The partial frame is discarded and data_out is cleared to 0.
- data_out changes only in DONE or on reset.

Test Plan:
- Reset, then single frame: clk_div=2, frame_bits=16; pulse trig_in 1 cycle; sensor model drives 0xA5C3 MSB-first on SCLK falling edges -> cs_n_out low exactly 68 cycles; 32 sclk_out edges with 16 rising; data_out=0xA5C3 with valid_out high 1 cycle at cs_n_out rise.
- Level trigger: hold trig_in high for 200 cycles -> exactly one frame; a second frame starts only after trig_in falls and rises again.
- Overrun: second trig_in rise 20 cycles into a frame -> overrun_out pulses 1 cycle; the frame completes with the correct data; no second frame follows.
- Back-to-back: trig_in rise on the cycle after valid_out -> new frame starts (cs_n_out falls next edge); data 0xFFFF then 0x0001 both captured correctly.
- Reset mid-frame: assert rst_in during SHIFT -> cs_n_out=1 and sclk_out=0 asynchronously, data_out=0, no valid_out; trig_in held high across reset release -> no frame starts.
- Default parameters with a timer at time_ms=1: 3 ticks -> 3 frames; each cs_n_out low for 850 cycles; SCLK period 50 cycles.
